// File: rtl/fetch_prefetch_queue_pkg.sv
// Shared types for the instruction-fetch prefetch queue.
package riscv_fetch_pkg;

  localparam int unsigned XLEN      = 64;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_prefetch_queue_fifo.sv
// DEPTH-entry synchronous FIFO of {pc, instr} pairs with flush; head is read combinationally.
module fetch_queue_fifo
  import riscv_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  fetch_entry_t               i_data,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output fetch_entry_t               o_head,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  fetch_entry_t    r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Fetch front end: owns fetch PC, issues req/ack word fetches, buffers results for IF/ID.
// Optional macro FETCH_STATS_EN adds drop_count and starve_cycles counters.
module fetch_prefetch_queue
  import riscv_fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       redirect_valid,
  input  logic [63:0]                redirect_pc,
  output logic                       imem_req,
  output logic [63:0]                imem_addr,
  input  logic                       imem_ack,
  input  logic [31:0]                imem_rdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_instr,
  output logic [63:0]                out_pc,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0]                drop_count,
  output logic [31:0]                starve_cycles
`endif
);

  localparam int unsigned CW = $clog2(DEPTH+1);

  fetch_state_t    r_state, w_state_nxt;
  logic [XLEN-1:0] r_fetch_pc, w_fetch_pc_nxt;
  logic [XLEN-1:0] r_addr, w_addr_nxt;
  logic [XLEN-1:0] w_pc_inc;
  logic            w_push, w_pop, w_flush;
  logic            w_has_room, w_room_after_push;
  logic [CW-1:0]   w_count;
  fetch_entry_t    w_head, w_push_data;

  assign w_pc_inc          = r_fetch_pc + 64'd4;
  assign out_valid         = (w_count != '0);
  assign w_pop             = out_valid && out_ready;
  assign w_flush           = redirect_valid;
  assign w_has_room        = (32'(w_count) < DEPTH);
  // A same-cycle pop keeps occupancy flat, and a request only exists with a free slot.
  assign w_room_after_push = w_pop || ((32'(w_count) + 32'd1) < DEPTH);
  assign w_push_data       = '{pc: r_fetch_pc, instr: imem_rdata};

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = redirect_valid ? redirect_pc : r_fetch_pc;
    w_addr_nxt     = r_addr;
    w_push         = 1'b0;
    case (r_state)
      IDLE: begin
        if (!redirect_valid && w_has_room) begin
          w_state_nxt = WAIT;
          w_addr_nxt  = r_fetch_pc;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          if (imem_ack) w_addr_nxt  = redirect_pc;
          else          w_state_nxt = DROP;
        end else if (imem_ack) begin
          w_push         = 1'b1;
          w_fetch_pc_nxt = w_pc_inc;
          if (w_room_after_push) w_addr_nxt  = w_pc_inc;
          else                   w_state_nxt = IDLE;
        end
      end
      DROP: begin
        if (imem_ack) begin
          w_state_nxt = WAIT;
          w_addr_nxt  = w_fetch_pc_nxt;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
      r_addr     <= RESET_PC;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_addr     <= w_addr_nxt;
    end
  end

  fetch_queue_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign imem_req  = (r_state != IDLE);
  assign imem_addr = r_addr;
  assign occupancy = w_count;
  assign out_instr = out_valid ? w_head.instr : NOP_INSTR;
  assign out_pc    = out_valid ? w_head.pc    : '0;

`ifdef FETCH_STATS_EN
  logic        w_drop;
  logic [15:0] r_drop_count;
  logic [31:0] r_starve_cycles;

  assign w_drop = imem_ack && ((r_state == DROP) || ((r_state == WAIT) && redirect_valid));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_drop_count    <= '0;
      r_starve_cycles <= '0;
    end else begin
      if (w_drop && (r_drop_count != '1)) r_drop_count <= r_drop_count + 16'd1;
      if (!out_valid && out_ready && (r_starve_cycles != '1))
        r_starve_cycles <= r_starve_cycles + 32'd1;
    end
  end

  assign drop_count    = r_drop_count;
  assign starve_cycles = r_starve_cycles;
`endif

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Self-checking bench: behavioural memory + expected-instruction queue model, randomized traffic.
module tb_fetch_prefetch_queue;
  import riscv_fetch_pkg::*;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned CW       = $clog2(DEPTH+1);
  localparam logic [63:0] RESET_PC = 64'h0;

  logic          clk = 1'b0;
  logic          reset, redirect_valid, imem_req, imem_ack, out_valid, out_ready;
  logic [63:0]   redirect_pc, imem_addr, out_pc;
  logic [31:0]   imem_rdata, out_instr;
  logic [CW-1:0] occupancy;
`ifdef FETCH_STATS_EN
  logic [15:0]   drop_count;
  logic [31:0]   starve_cycles;
`endif

  fetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .occupancy      (occupancy)
`ifdef FETCH_STATS_EN
    ,
    .drop_count     (drop_count),
    .starve_cycles  (starve_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        q[$];
  int unsigned n_tests = 0, n_fail = 0;
  logic [63:0] exp_pc = RESET_PC;
  logic [63:0] mem_addr = '0;
  bit          mem_busy = 0, mem_stale = 0, ack_now = 0, just_reset = 0, popped_now = 0;
  int unsigned mem_cnt = 0, n_pops = 0, n_drops_m = 0, n_starve_m = 0;
  int          lat_mode = 0;

  function automatic logic [31:0] instr_of(logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0003;
  endfunction

  // Negedge observation: DUT outputs vs model, plus memory-side protocol tracking.
  task automatic sense();
    @(negedge clk);
    n_tests++;
    if (out_valid !== (q.size() != 0)) begin
      n_fail++; $display("FAIL out_valid: got %b expected %b", out_valid, q.size() != 0);
    end
    n_tests++;
    if (32'(occupancy) !== 32'(q.size())) begin
      n_fail++; $display("FAIL occupancy: got %0d expected %0d", occupancy, q.size());
    end
    n_tests++;
    if (q.size() != 0) begin
      if (out_pc !== q[0].pc || out_instr !== q[0].instr) begin
        n_fail++;
        $display("FAIL head: got pc=%h instr=%h expected pc=%h instr=%h", out_pc, out_instr, q[0].pc, q[0].instr);
      end
    end else if (out_pc !== 64'h0 || out_instr !== NOP_INSTR) begin
      n_fail++; $display("FAIL empty_head: got pc=%h instr=%h expected pc=0 instr=%h", out_pc, out_instr, NOP_INSTR);
    end
    if (q.size() == DEPTH) begin
      n_tests++;
      if (imem_req !== 1'b0) begin
        n_fail++; $display("FAIL req_when_full: got %b expected 0", imem_req);
      end
    end
    if (just_reset) begin
      just_reset = 0;
      n_tests++;
      if (imem_req !== 1'b0 || imem_addr !== RESET_PC) begin
        n_fail++; $display("FAIL reset_req: got req=%b addr=%h expected req=0 addr=%h", imem_req, imem_addr, RESET_PC);
      end
    end
    if (mem_busy) begin
      n_tests++;
      if (imem_req !== 1'b1 || imem_addr !== mem_addr) begin
        n_fail++; $display("FAIL req_hold: got req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, mem_addr);
      end
    end else if (imem_req === 1'b1) begin
      n_tests++;
      if (imem_addr !== exp_pc) begin
        n_fail++; $display("FAIL fetch_addr: got %h expected %h", imem_addr, exp_pc);
      end
      mem_busy  = 1;
      mem_stale = 0;
      mem_addr  = imem_addr;
      mem_cnt   = (lat_mode < 0) ? $urandom_range(0, 3) : lat_mode;
    end
    ack_now = mem_busy && (mem_cnt == 0);
    if (mem_busy && mem_cnt != 0) mem_cnt--;
  endtask

  // Drive inputs for the coming posedge and advance the model by one cycle.
  task automatic apply(input bit rst_n, input bit redir, input logic [63:0] tgt,
                       input bit rdy, input bit force_ack);
    reset          = rst_n;
    redirect_valid = redir;
    redirect_pc    = tgt;
    out_ready      = rdy;
    popped_now     = 0;
    if (!rst_n) begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      q.delete();
      exp_pc     = RESET_PC;
      mem_busy   = 0;
      mem_stale  = 0;
      just_reset = 1;
      n_drops_m  = 0;
      n_starve_m = 0;
    end else begin
      imem_ack   = ack_now || force_ack;
      imem_rdata = ack_now ? instr_of(mem_addr) : $urandom;
      if (q.size() == 0 && rdy) n_starve_m++;
      if (q.size() != 0 && rdy) begin
        popped_now = 1;
        n_pops++;
        void'(q.pop_front());
      end
      if (ack_now) begin
        mem_busy = 0;
        if (mem_stale || redir) n_drops_m++;
        else begin
          q.push_back('{pc: mem_addr, instr: instr_of(mem_addr)});
          exp_pc = exp_pc + 64'd4;
        end
      end
      if (redir) begin
        q.delete();
        exp_pc = tgt;
        if (mem_busy) mem_stale = 1;
      end
    end
    ack_now = 0;
  endtask

  task automatic cycle(input bit redir, input logic [63:0] tgt, input bit rdy);
    sense();
    apply(1, redir, tgt, rdy, 0);
  endtask

  task automatic do_reset();
    sense();
    apply(0, 0, 64'h0, 0, 0);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    q.delete(); exp_pc = RESET_PC; mem_busy = 0; just_reset = 1;
    sense();
    n_tests++;
    if (out_valid !== 1'b0 || occupancy !== '0) begin
      n_fail++; $display("FAIL reset_out: got valid=%b occ=%0d expected 0/0", out_valid, occupancy);
    end
    apply(1, 0, 64'h0, 0, 0);
  endtask

  task automatic test_sequential();
    do_reset();
    lat_mode = 2;
    n_pops   = 0;
    repeat (40) cycle(0, 64'h0, 1);
    n_tests++;
    if (n_pops < 8) begin
      n_fail++; $display("FAIL seq_throughput: got %0d pops expected >= 8", n_pops);
    end
  endtask

  task automatic test_full();
    do_reset();
    lat_mode = 0;
    repeat (12) cycle(0, 64'h0, 0);
    sense();
    n_tests++;
    if (32'(occupancy) !== DEPTH || imem_req !== 1'b0) begin
      n_fail++; $display("FAIL full_stall: got occ=%0d req=%b expected occ=%0d req=0", occupancy, imem_req, DEPTH);
    end
    apply(1, 0, 64'h0, 1, 0);
    n_pops = 0;
    repeat (10) cycle(0, 64'h0, 1);
    n_tests++;
    if (n_pops < 4 || exp_pc < 64'h14) begin
      n_fail++; $display("FAIL full_drain: got pops=%0d next_pc=%h expected pops>=4 next_pc>=14", n_pops, exp_pc);
    end
  endtask

  task automatic test_redirect_pending();
    bit found = 0, got = 0;
    do_reset();
    lat_mode = 6;
    for (int i = 0; i < 100 && !found; i++) begin
      sense();
      if (mem_busy && mem_addr == 64'h8 && !ack_now) begin
        apply(1, 1, 64'h100, 1, 0);
        found = 1;
      end else apply(1, 0, 64'h0, 1, 0);
    end
    n_tests++;
    if (!found) begin
      n_fail++; $display("FAIL redir_pend_timeout: got no pending req to 8 expected one");
    end
    sense();
    n_tests++;
    if (occupancy !== '0) begin
      n_fail++; $display("FAIL redir_pend_occ: got %0d expected 0", occupancy);
    end
    apply(1, 0, 64'h0, 1, 0);
    for (int i = 0; i < 60 && !got; i++) begin
      sense();
      if (out_valid === 1'b1) begin
        got = 1;
        n_tests++;
        if (out_pc !== 64'h100) begin
          n_fail++; $display("FAIL redir_pend_first: got %h expected 100", out_pc);
        end
      end
      apply(1, 0, 64'h0, 1, 0);
    end
    n_tests++;
    if (!got) begin
      n_fail++; $display("FAIL redir_pend_refill: got no output expected pc 100");
    end
  endtask

  task automatic test_redirect_ack();
    bit found = 0;
    do_reset();
    lat_mode = 1;
    for (int i = 0; i < 60 && !found; i++) begin
      sense();
      if (mem_busy && mem_addr == 64'h4 && ack_now) begin
        apply(1, 1, 64'h200, 1, 0);
        found = 1;
      end else apply(1, 0, 64'h0, 1, 0);
    end
    n_tests++;
    if (!found) begin
      n_fail++; $display("FAIL redir_ack_timeout: got no ack of 4 expected one");
    end
    sense();
    n_tests++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h200 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL redir_ack: got req=%b addr=%h valid=%b expected 1/200/0", imem_req, imem_addr, out_valid);
    end
    apply(1, 0, 64'h0, 1, 0);
    repeat (12) cycle(0, 64'h0, 1);
  endtask

  task automatic test_reset_mid_wait();
    bit found = 0;
    do_reset();
    lat_mode = 5;
    for (int i = 0; i < 20 && !found; i++) begin
      sense();
      if (mem_busy && !ack_now) begin
        apply(0, 0, 64'h0, 0, 0);
        found = 1;
      end else apply(1, 0, 64'h0, 0, 0);
    end
    n_tests++;
    if (!found) begin
      n_fail++; $display("FAIL rst_mid_timeout: got no outstanding req expected one");
    end
    sense();
    apply(1, 0, 64'h0, 0, 1);
    sense();
    n_tests++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_stale_ack: got req=%b addr=%h valid=%b expected 1/%h/0", imem_req, imem_addr, out_valid, RESET_PC);
    end
    apply(1, 0, 64'h0, 0, 0);
    repeat (15) cycle(0, 64'h0, 0);
  endtask

  task automatic test_random();
    logic [63:0] t;
    do_reset();
    lat_mode = -1;
    for (int i = 0; i < 500; i++) begin
      t = {$urandom, $urandom};
      t[1:0] = 2'b00;
      if ($urandom_range(0, 3) == 0) t = 64'hFFFF_FFFF_FFFF_FFF4;
      cycle($urandom_range(0, 24) == 0, t, $urandom_range(0, 9) < 7);
    end
  endtask

`ifdef FETCH_STATS_EN
  task automatic test_stats();
    int unsigned phase = 0;
    do_reset();
    lat_mode = 3;
    for (int i = 0; i < 80 && phase < 2; i++) begin
      sense();
      if (phase == 0 && mem_busy && !ack_now) begin
        apply(1, 1, 64'h300, 0, 0);
        phase = 1;
      end else if (phase == 1 && mem_busy && !mem_stale && ack_now) begin
        apply(1, 1, 64'h400, 0, 0);
        phase = 2;
      end else apply(1, 0, 64'h0, 0, 0);
    end
    repeat (5) cycle(0, 64'h0, 1);
    sense();
    n_tests++;
    if (drop_count !== 16'd2 || 32'(drop_count) !== n_drops_m) begin
      n_fail++; $display("FAIL drop_count: got %0d expected 2 (model %0d)", drop_count, n_drops_m);
    end
    n_tests++;
    if (starve_cycles !== n_starve_m) begin
      n_fail++; $display("FAIL starve_cycles: got %0d expected %0d", starve_cycles, n_starve_m);
    end
    apply(1, 0, 64'h0, 0, 0);
  endtask
`endif

  initial begin
    reset = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_ack = 1'b0; imem_rdata = '0; out_ready = 1'b0;
    test_reset();
    test_sequential();
    test_full();
    test_redirect_pending();
    test_redirect_ack();
    test_reset_mid_wait();
    test_random();
`ifdef FETCH_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
